// File: rtl/class_demux_fifo.sv
// Class demultiplexer: routes each word by its top SEL_W bits into one of CH
// per-channel FIFOs with valid/pop handshake. Optional CLASS_DEMUX_STATS_EN adds saturating accept counters.
module class_demux_fifo #(
    parameter int         DATA_W    = 12,
    parameter int         CH        = 4,
    parameter int         SEL_W     = $clog2(CH),
    parameter int         DEPTH     = 4,
    parameter logic [3:0] INIT_CODE = 4'b0001
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic [3:0]           states,
    input  logic                 in_valid,
    input  logic [DATA_W-1:0]    in_data,
    output logic                 in_ready,
    output logic [CH-1:0]        out_valid,
    output logic [CH*DATA_W-1:0] out_data,
    input  logic [CH-1:0]        out_pop,
    output logic [CH-1:0]        fifo_full,
    output logic [CH-1:0]        fifo_empty,
    output logic [CH*8-1:0]      stats_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic             w_flush;
    logic [SEL_W-1:0] w_sel;
    logic             w_accept;

    assign w_flush  = (states == INIT_CODE);
    assign w_sel    = in_data[DATA_W-1 -: SEL_W];
    assign in_ready = !w_flush && !fifo_full[w_sel];
    assign w_accept = in_valid && in_ready;

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_ch
            logic [DATA_W-1:0] r_mem [DEPTH];
            logic [PTR_W-1:0]  r_wptr;
            logic [PTR_W-1:0]  r_rptr;
            logic [PTR_W-1:0]  w_rptr_inc;
            logic [CNT_W-1:0]  r_count;
            logic [CNT_W-1:0]  w_count_next;
            logic              r_valid;
            logic [DATA_W-1:0] r_head;
            logic [DATA_W-1:0] w_head_next;
            logic              w_push;
            logic              w_pop;

            assign w_push     = w_accept && (w_sel == SEL_W'(gi));
            assign w_pop      = out_pop[gi] && r_valid && !w_flush;
            assign w_rptr_inc = r_rptr + PTR_W'(1);

            // Storage has no reset; the head register keeps stale contents off out_data.
            always_ff @(posedge clk) begin
                if (w_push) begin
                    r_mem[r_wptr] <= in_data;
                end
            end

            always_comb begin
                w_count_next = r_count;
                case ({w_push, w_pop})
                    2'b10:   w_count_next = r_count + CNT_W'(1);
                    2'b01:   w_count_next = r_count - CNT_W'(1);
                    default: w_count_next = r_count;
                endcase
            end

            // Head follows the entry at rptr; a push into a channel that is (or
            // becomes) empty this cycle bypasses storage so latency stays one cycle.
            always_comb begin
                w_head_next = r_head;
                if (w_push && ((r_count == '0) || (w_pop && r_count == CNT_W'(1)))) begin
                    w_head_next = in_data;
                end else if (w_pop && r_count == CNT_W'(1)) begin
                    w_head_next = '0;
                end else if (w_pop) begin
                    w_head_next = r_mem[w_rptr_inc];
                end
            end

            always_ff @(posedge clk or negedge reset_L) begin
                if (!reset_L) begin
                    r_wptr  <= '0;
                    r_rptr  <= '0;
                    r_count <= '0;
                    r_valid <= 1'b0;
                    r_head  <= '0;
                end else if (w_flush) begin
                    r_wptr  <= '0;
                    r_rptr  <= '0;
                    r_count <= '0;
                    r_valid <= 1'b0;
                    r_head  <= '0;
                end else begin
                    if (w_push) begin
                        r_wptr <= r_wptr + PTR_W'(1);
                    end
                    if (w_pop) begin
                        r_rptr <= w_rptr_inc;
                    end
                    r_count <= w_count_next;
                    r_valid <= (w_count_next != '0);
                    r_head  <= w_head_next;
                end
            end

            assign out_valid[gi]                   = r_valid;
            assign out_data[gi*DATA_W +: DATA_W]   = r_head;
            assign fifo_full[gi]                   = (r_count == CNT_W'(DEPTH));
            assign fifo_empty[gi]                  = (r_count == '0);

`ifdef CLASS_DEMUX_STATS_EN
            logic [7:0] r_stats;

            always_ff @(posedge clk or negedge reset_L) begin
                if (!reset_L) begin
                    r_stats <= 8'h00;
                end else if (w_flush) begin
                    r_stats <= 8'h00;
                end else if (w_push && r_stats != 8'hFF) begin
                    r_stats <= r_stats + 8'h01;
                end
            end

            assign stats_cnt[gi*8 +: 8] = r_stats;
`else
            assign stats_cnt[gi*8 +: 8] = 8'h00;
`endif
        end
    endgenerate

endmodule
